// File: rtl/baud_acq_gen.sv
// Baud-rate and acquisition-strobe generator for the UART Rx/Tx cores.
// A bit is RU acquisition periods of P+1 clocks followed by RD periods of P clocks.
module baud_acq_gen #(
    parameter int PERIOD_W = 12,
    parameter int NUM_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_En_i,
    input  logic                p_Sync_i,
    input  logic [PERIOD_W-1:0] AcqPeriod_i,
    input  logic [NUM_W-1:0]    RoundUpNum_i,
    input  logic [NUM_W-1:0]    RoundDownNum_i,
    output logic                AcqSig_o,
    output logic                BaudSig_o,
    output logic [NUM_W:0]      AcqIndex_o,
    output logic                p_CfgErr_o
);

    localparam logic [PERIOD_W:0] ONE_P = 1;
    localparam logic [NUM_W:0]    ONE_N = 1;

    logic [PERIOD_W:0]   cnt;
    logic [PERIOD_W-1:0] p_sh;
    logic [NUM_W-1:0]    ru_sh;
    logic [NUM_W-1:0]    rd_sh;

    logic [NUM_W:0]      n_sh;
    logic [NUM_W:0]      n_in;
    logic [PERIOD_W:0]   len_m1;
    logic                term;
    logic                last;
    logic                hold;
    logic                bit_end;
    logic                load_sh;
    logic                cfg_bad_in;

    always_comb begin
        n_sh   = {1'b0, ru_sh} + {1'b0, rd_sh};
        n_in   = {1'b0, RoundUpNum_i} + {1'b0, RoundDownNum_i};
        // Round-up periods are one clock longer; computed one bit wider so P=max does not wrap.
        len_m1 = (AcqIndex_o < {1'b0, ru_sh}) ? {1'b0, p_sh} : ({1'b0, p_sh} - ONE_P);
        term   = (cnt == len_m1);
        last   = (AcqIndex_o == (n_sh - ONE_N));
        hold   = !p_En_i || p_CfgErr_o || p_Sync_i;
        bit_end    = !hold && term && last;
        load_sh    = !p_En_i || p_Sync_i || bit_end;
        cfg_bad_in = (AcqPeriod_i < PERIOD_W'(2)) || (n_in == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            p_sh       <= '0;
            ru_sh      <= '0;
            rd_sh      <= '0;
            AcqSig_o   <= 1'b0;
            BaudSig_o  <= 1'b0;
            AcqIndex_o <= '0;
            p_CfgErr_o <= 1'b0;
        end else begin
            // Shadows only move between bits, so a bit in progress is never distorted.
            if (load_sh) begin
                p_sh       <= AcqPeriod_i;
                ru_sh      <= RoundUpNum_i;
                rd_sh      <= RoundDownNum_i;
                p_CfgErr_o <= cfg_bad_in;
            end
            AcqSig_o  <= 1'b0;
            BaudSig_o <= 1'b0;
            if (hold) begin
                cnt        <= '0;
                AcqIndex_o <= '0;
            end else if (term) begin
                cnt      <= '0;
                AcqSig_o <= 1'b1;
                if (last) begin
                    AcqIndex_o <= '0;
                    BaudSig_o  <= 1'b1;
                end else begin
                    AcqIndex_o <= AcqIndex_o + ONE_N;
                end
            end else begin
                cnt <= cnt + ONE_P;
            end
        end
    end

endmodule

// File: doc/baud_acq_gen.md
Name: baud_acq_gen

Overview:
- Baud-rate and acquisition-strobe generator that feeds the Rx and Tx cores of the UART.
- Produces a per-acquisition strobe (AcqSig_o) and a per-bit strobe (BaudSig_o) from the 40 MHz system clock.
- Bit-width error stays under one system clock: each bit is built from RoundUpNum acquisition periods of AcqPeriod+1 clocks, followed by RoundDownNum periods of AcqPeriod clocks.
- Configuration comes from the control-core registers. p_Sync_i re-phases the generator so the Rx core can align sampling to a start-bit edge.

Parameters:
- PERIOD_W, 12, width of the acquisition period field.
- NUM_W, 4, width of each of the round-up and round-down count fields.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  asynchronous, active-low reset.
- p_En_i  in  1  generator enable, active high.
- p_Sync_i  in  1  one-cycle phase restart request from the Rx core.
- AcqPeriod_i  in  PERIOD_W  base acquisition period P, in clocks.
- RoundUpNum_i  in  NUM_W  RU, the number of P+1 periods per bit.
- RoundDownNum_i  in  NUM_W  RD, the number of P periods per bit.
- AcqSig_o  out  1  one-clock strobe at the end of each acquisition period.
- BaudSig_o  out  1  one-clock strobe at the end of each bit.
- AcqIndex_o  out  NUM_W+1  index (0..N-1) of the acquisition period currently running within the bit.
- p_CfgErr_o  out  1  configuration illegal; generator halted.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Cycle counter, index and shadow registers are 0.
- Derived values:
  - N = RU+RD, computed at NUM_W+1 bits with no overflow (maximum 30).
  - Period length len = P+1 while index < RU, otherwise len = P.
  - len is computed at PERIOD_W+1 bits, so P=4095 gives len=4096 with no wrap.
- Shadow registers (P, RU, RD):
  - Loaded from the inputs on every edge where p_En_i=0, p_Sync_i=1, or the end of a bit is reached.
  - Input changes mid-bit therefore never distort the bit in progress.
- Configuration check:
  - p_CfgErr_o = registered (shadow P < 2 OR shadow N == 0).
  - While it is 1, the counters are held at 0 and AcqSig_o/BaudSig_o stay 0.
  - It is re-evaluated at every shadow load.
- Disabled (p_En_i=0):
  - Counters are held at 0.
  - AcqSig_o and BaudSig_o are 0 on the next edge.
  - AcqIndex_o = 0.
- Counting, with edge 1 defined as the first edge at which p_En_i is sampled 1:
  - The cycle counter increments each edge.
  - At an edge where the sampled counter equals len-1: the counter goes to 0, AcqSig_o=1 for that clock, and the index advances.
  - The first AcqSig_o therefore rises at edge len; later pulses are spaced exactly by their period length.
- End of bit: when the sampled index is N-1 and the counter terminates:
  - BaudSig_o=1 coincident with AcqSig_o.
  - Index wraps to 0 and the shadow registers reload.
  - Bit width = RU*(P+1) + RD*P clocks.
- Sync (p_Sync_i=1):
  - On that edge, counter and index go to 0, shadows reload, and no strobe is produced, even if a terminal count coincides (sync wins).
  - The next AcqSig_o follows len clocks later.
  - Sync while disabled has no effect beyond the shadow load.
- Simultaneous events, priority: rst > p_En_i=0 > p_CfgErr > p_Sync_i > terminal count.
- Deasserting p_En_i mid-bit discards the partial bit; no strobe is emitted.
- All outputs are registered. No combinational path exists from any input to any output.

Test Plan:
- Compensation: P=4, RU=1, RD=2, enable → AcqSig at edges 5, 9, 13, 18, 22, 26; BaudSig at edges 13 and 26 only; AcqIndex sequence 0,1,2,0.
- Shadow stability: P=10, RU=0, RD=4 running; change P to 20 at mid-bit → current bit still 40 clocks; next bit 80 clocks.
- Sync: P=8, RU=0, RD=2; pulse p_Sync_i at the edge where the counter is at 7 (terminal) → no strobe that edge; next AcqSig 8 clocks later with AcqIndex=0.
- Config error: P=1 or RU=RD=0, then enable → p_CfgErr_o=1, no strobes; set P=4, RU=0, RD=1 with p_En_i toggled → p_CfgErr_o=0, BaudSig every 4 clocks.
- Boundary: P=4095, RU=15, RD=15 → bit width 15*4096 + 15*4095 = 122865 clocks; AcqIndex reaches 29 then wraps to 0.
- Reset and disable mid-operation: assert rst mid-period → outputs 0 immediately (asynchronous); drop p_En_i mid-bit → no strobes; re-enable → first AcqSig at edge len.
